mux_b_pipe: RTL and testbench
=============================

// Module: mux_b_pipe
// PURPOSE
//  Parametrised, registered operand-B source selector for the execute stage.
//  Picks one of NSRC source words (register-file B, constant unit, ALU/mem forwards)
//  per transaction, tags it with the chosen source index and buffers it in a
//  2-entry skid buffer with valid/ready handshakes on both sides.
// PARAMETERS
//  WIDTH  8  datapath width of every source word and of out_data
//  NSRC   4  number of sources on src_bus; src 0 = register B, src 1 = constant unit
//  SELW   2  width of sel/out_src; NSRC <= 2**SELW
// PORTS
//  clk        in   1            single clock, all state on rising edge
//  reset_n    in   1            asynchronous, active-low reset
//  flush      in   1            sync flush: empties buffer, drops in-flight words
//  in_valid   in   1            upstream offers sel/src_bus this cycle
//  in_ready   out  1            stage can accept; registered
//  sel        in   SELW         source index for this transaction
//  src_bus    in   NSRC*WIDTH   source k at bits [k*WIDTH +: WIDTH]
//  out_valid  out  1            out_data/out_src hold a valid operand
//  out_ready  in   1            downstream consumes when out_valid && out_ready
//  out_data   out  WIDTH        selected operand B
//  out_src    out  SELW         source index actually used
//  sel_err    out  1            sticky out-of-range select flag (see CONFIGURATION)
//  err_clr    in   1            sync clear of sel_err
// BEHAVIOUR
//  - Accept = in_valid && in_ready; pop = out_valid && out_ready.
//  - Selection: sel < NSRC -> word sel; sel >= NSRC -> word 0, out_src = 0.
//  - Buffer: main reg (drives outputs) + skid reg. States EMPTY, ONE, FULL.
//    EMPTY: accept -> main, go ONE.
//    ONE:   accept&pop -> main reloads, stay ONE; accept only -> skid, go FULL;
//           pop only -> go EMPTY.
//    FULL:  in_ready=0; pop -> skid moves to main, go ONE.
//  - in_ready = (state != FULL), registered from next-state.
//  - Latency: accept in cycle N -> out_valid in N+1. Throughput 1/cycle.
//    Order strictly preserved; no word duplicated or lost except by flush.
//  - out_data/out_src stable while out_valid && !out_ready.
//  - flush: next state EMPTY, out_valid=0, in_ready=1; a same-cycle accept is
//    discarded. flush wins over accept and pop.
//  - Reset (reset_n=0, any time incl. mid-transfer): state EMPTY, out_valid=0,
//    out_data=0, out_src=0, in_ready=1, sel_err=0. Skid contents don't care.
//  - No arithmetic; words pass unmodified at WIDTH bits.
// CONFIGURATION
//  MUX_B_SEL_ERR_EN defined: sel_err sets on an accept with sel >= NSRC, stays
//    set until err_clr (set wins if same cycle); out-of-range still selects src 0.
//  Not defined: sel_err tied 0, err_clr ignored, no flag logic synthesised.
// TESTING (WIDTH=8, NSRC=4, SELW=2; src_bus = {8'h44,8'h33,8'h22,8'h11})
//  1 reset, then in_valid=1 sel=1 out_ready=1 -> next cycle out_valid=1,
//    out_data=8'h22, out_src=1; outputs 0 and in_ready=1 during reset.
//  2 out_ready=0, send sel=0,2,3 back-to-back -> accepts 0,2; in_ready=0 after 2nd;
//    raise out_ready -> outputs 11,33 in order, then 44 accepted, 3 words total.
//  3 streaming sel=0..3 with out_ready=1 every cycle -> one output per cycle,
//    11,22,33,44, no bubbles.
//  4 FULL state, assert flush with in_valid=1 -> next cycle out_valid=0,
//    in_ready=1; flushed/offered words never appear.
//  5 NSRC=3, sel=3 with MUX_B_SEL_ERR_EN -> out_data=8'h11, out_src=0, sel_err=1
//    until err_clr; without macro sel_err stays 0.
//  6 reset_n pulsed low while FULL and out_ready=0 -> outputs 0 immediately,
//    normal accept on first cycle after release.

Source files
------------

// File: rtl/mux_b_pipe.sv
// Registered operand-B source selector with a 2-entry skid buffer and valid/ready on both sides.
// Optional sticky out-of-range select flag is built only when MUX_B_SEL_ERR_EN is defined.
module mux_b_pipe #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 4,
  parameter int SELW  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SELW-1:0]       sel,
  input  logic [NSRC*WIDTH-1:0] src_bus,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_src,
  output logic                  sel_err,
  input  logic                  err_clr
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  main_data_q, main_data_d;
  logic [SELW-1:0]   main_src_q, main_src_d;
  logic [WIDTH-1:0]  skid_data_q, skid_data_d;
  logic [SELW-1:0]   skid_src_q, skid_src_d;
  logic              in_ready_q;
  logic              accept, pop;
  logic [WIDTH-1:0]  sel_data;
  logic [SELW-1:0]   sel_src;

  // Out-of-range selects fall through to source 0 because no loop index matches them.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel_data = src_bus[WIDTH-1:0];
    sel_src  = '0;
    for (int k = 1; k < NSRC; k++) begin
      if (sel == SELW'(k)) begin
        sel_data = src_bus[k*WIDTH +: WIDTH];
        sel_src  = SELW'(k);
      end
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_src_d  = main_src_q;
    skid_data_d = skid_data_q;
    skid_src_d  = skid_src_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_data_d = sel_data;
            main_src_d  = sel_src;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_data_d = sel_data;
            main_src_d  = sel_src;
          end else if (accept) begin
            skid_data_d = sel_data;
            skid_src_d  = sel_src;
            state_d     = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_data_d = skid_data_q;
            main_src_d  = skid_src_q;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_src_q  <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_src_q  <= main_src_d;
      in_ready_q  <= (state_d != FULL);
    end
  end

  // NOTE: the skid entry is only read when FULL, so it carries no reset.
  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
    skid_src_q  <= skid_src_d;
  end

  assign in_ready = in_ready_q;
  assign out_data = main_data_q;
  assign out_src  = main_src_q;

`ifdef MUX_B_SEL_ERR_EN
  logic sel_err_q;
  logic sel_bad;

  assign sel_bad = (sel != sel_src);

  // A new out-of-range accept outranks a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_err_q <= 1'b0;
    end else if (accept && sel_bad) begin
      sel_err_q <= 1'b1;
    end else if (err_clr) begin
      sel_err_q <= 1'b0;
    end
  end

  assign sel_err = sel_err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign sel_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mux_b_pipe.sv
// Self-checking bench for mux_b_pipe: directed scenarios plus randomized traffic checked
// against a depth-2 FIFO model, on an NSRC=4 instance and an NSRC=3 instance.
module tb_mux_b_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [1:0]  sel;
  logic        out_ready;
  logic        err_clr;
  logic [31:0] src_bus4;
  logic [23:0] src_bus3;

  logic        in_ready4, out_valid4, sel_err4;
  logic [7:0]  out_data4;
  logic [1:0]  out_src4;
  logic        in_ready3, out_valid3, sel_err3;
  logic [7:0]  out_data3;
  logic [1:0]  out_src3;

  int checks = 0;
  int errors = 0;

`ifdef MUX_B_SEL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  mux_b_pipe #(.WIDTH(8), .NSRC(4), .SELW(2)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready4), .sel(sel), .src_bus(src_bus4), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .out_src(out_src4),
    .sel_err(sel_err4), .err_clr(err_clr)
  );

  mux_b_pipe #(.WIDTH(8), .NSRC(3), .SELW(2)) dut3 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready3), .sel(sel), .src_bus(src_bus3), .out_valid(out_valid3),
    .out_ready(out_ready), .out_data(out_data3), .out_src(out_src3),
    .sel_err(sel_err3), .err_clr(err_clr)
  );

  // Source k carries 8'h11*(k+1); out-of-range selects map to source 0.
  function automatic logic [9:0] ref_word(input int s, input int nsrc);
    int k;
    k = (s < nsrc) ? s : 0;
    return {2'(k), 8'(8'h11 * (k + 1))};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b0;
    flush     = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd1;
    out_ready = 1'b1;
    flush     = 1'b0;
    err_clr   = 1'b0;
    step();
    checks++;
    if ({out_valid4, out_data4, out_src4, in_ready4, sel_err4} !== {1'b0, 8'h00, 2'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h s=%0d rdy=%b err=%b, want v=0 d=00 s=0 rdy=1 err=0",
               out_valid4, out_data4, out_src4, in_ready4, sel_err4);
    end
    checks++;
    if ({out_valid3, in_ready3, sel_err3} !== 3'b010) begin
      errors++;
      $display("FAIL reset_state3: got v=%b rdy=%b err=%b, want v=0 rdy=1 err=0",
               out_valid3, in_ready3, sel_err3);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if ({out_valid4, out_data4, out_src4} !== {1'b1, 8'h22, 2'd1}) begin
      errors++;
      $display("FAIL first_accept: got v=%b d=%h s=%0d, want v=1 d=22 s=1",
               out_valid4, out_data4, out_src4);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL first_drain: got v=%b, want 0", out_valid4);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [3];
    want = '{8'h11, 8'h33, 8'h44};
    do_reset();
    in_valid = 1'b1;
    sel      = 2'd0;
    step();
    sel = 2'd2;
    step();
    checks++;
    if ({in_ready4, out_valid4, out_data4} !== {1'b0, 1'b1, want[0]}) begin
      errors++;
      $display("FAIL b2b_full: got rdy=%b v=%b d=%h, want rdy=0 v=1 d=%h",
               in_ready4, out_valid4, out_data4, want[0]);
    end
    sel = 2'd3;
    step();
    checks++;
    if ({in_ready4, out_data4} !== {1'b0, want[0]}) begin
      errors++;
      $display("FAIL b2b_stall: got rdy=%b d=%h, want rdy=0 d=%h", in_ready4, out_data4, want[0]);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if ({out_valid4, out_data4, out_src4, in_ready4} !== {1'b1, want[1], 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL b2b_second: got v=%b d=%h s=%0d rdy=%b, want v=1 d=%h s=2 rdy=1",
               out_valid4, out_data4, out_src4, in_ready4, want[1]);
    end
    step();
    checks++;
    if ({out_valid4, out_data4, out_src4} !== {1'b1, want[2], 2'd3}) begin
      errors++;
      $display("FAIL b2b_third: got v=%b d=%h s=%0d, want v=1 d=%h s=3",
               out_valid4, out_data4, out_src4, want[2]);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: got v=%b after 3 words, want 0", out_valid4);
    end
  endtask

  task automatic test_streaming();
    logic [9:0] w;
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      step();
      w = ref_word(i, 4);
      checks++;
      if ({out_valid4, out_src4, out_data4} !== {1'b1, w}) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b s=%0d d=%h, want v=1 s=%0d d=%h",
                 i, out_valid4, out_src4, out_data4, w[9:8], w[7:0]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: got v=%b, want 0", out_valid4);
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1;
    sel      = 2'd0;
    step();
    sel = 2'd1;
    step();
    checks++;
    if (in_ready4 !== 1'b0) begin
      errors++;
      $display("FAIL flush_prefull: got rdy=%b, want 0", in_ready4);
    end
    flush = 1'b1;
    sel   = 2'd2;
    step();
    checks++;
    if ({out_valid4, in_ready4} !== 2'b01) begin
      errors++;
      $display("FAIL flush_state: got v=%b rdy=%b, want v=0 rdy=1", out_valid4, in_ready4);
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    checks++;
    if (out_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL flush_ghost: got v=%b d=%h, want v=0", out_valid4, out_data4);
    end
    in_valid = 1'b1;
    sel      = 2'd3;
    step();
    checks++;
    if ({out_valid4, out_data4} !== {1'b1, 8'h44}) begin
      errors++;
      $display("FAIL flush_after: got v=%b d=%h, want v=1 d=44", out_valid4, out_data4);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_sel_err();
    do_reset();
    in_valid  = 1'b1;
    sel       = 2'd3;
    out_ready = 1'b1;
    step();
    checks++;
    if ({out_valid3, out_data3, out_src3, sel_err3} !== {1'b1, 8'h11, 2'd0, ERR_EN}) begin
      errors++;
      $display("FAIL oor_select: got v=%b d=%h s=%0d err=%b, want v=1 d=11 s=0 err=%b",
               out_valid3, out_data3, out_src3, sel_err3, ERR_EN);
    end
    in_valid = 1'b0;
    step();
    step();
    checks++;
    if (sel_err3 !== ERR_EN) begin
      errors++;
      $display("FAIL oor_sticky: got err=%b, want %b", sel_err3, ERR_EN);
    end
    in_valid = 1'b1;
    err_clr  = 1'b1;
    step();
    checks++;
    if (sel_err3 !== ERR_EN) begin
      errors++;
      $display("FAIL oor_set_wins: got err=%b, want %b", sel_err3, ERR_EN);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (sel_err3 !== 1'b0) begin
      errors++;
      $display("FAIL oor_clear: got err=%b, want 0", sel_err3);
    end
    err_clr = 1'b0;
    checks++;
    if (sel_err4 !== 1'b0) begin
      errors++;
      $display("FAIL inrange_no_err: got err=%b, want 0", sel_err4);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    in_valid = 1'b1;
    sel      = 2'd0;
    step();
    sel = 2'd1;
    step();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid4, out_data4, out_src4, in_ready4} !== {1'b0, 8'h00, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: got v=%b d=%h s=%0d rdy=%b, want v=0 d=00 s=0 rdy=1",
               out_valid4, out_data4, out_src4, in_ready4);
    end
    step();
    reset_n   = 1'b1;
    sel       = 2'd2;
    out_ready = 1'b1;
    step();
    checks++;
    if ({out_valid4, out_data4, out_src4} !== {1'b1, 8'h33, 2'd2}) begin
      errors++;
      $display("FAIL post_reset_accept: got v=%b d=%h s=%0d, want v=1 d=33 s=2",
               out_valid4, out_data4, out_src4);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [9:0] q4[$];
    logic [9:0] q3[$];
    bit acc4, pop4, acc3, pop3;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      acc4 = in_valid && (q4.size() < 2);
      pop4 = out_ready && (q4.size() > 0);
      acc3 = in_valid && (q3.size() < 2);
      pop3 = out_ready && (q3.size() > 0);
      step();
      if (flush) begin
        q4.delete();
        q3.delete();
      end else begin
        if (pop4) void'(q4.pop_front());
        if (acc4) q4.push_back(ref_word(int'(sel), 4));
        if (pop3) void'(q3.pop_front());
        if (acc3) q3.push_back(ref_word(int'(sel), 3));
      end
      checks++;
      if ({out_valid4, in_ready4} !== {q4.size() > 0, q4.size() < 2} ||
          (q4.size() > 0 && {out_src4, out_data4} !== q4[0])) begin
        errors++;
        $display("FAIL rand4 cycle %0d: got v=%b rdy=%b s=%0d d=%h, want depth=%0d head=%h",
                 c, out_valid4, in_ready4, out_src4, out_data4, q4.size(),
                 (q4.size() > 0) ? q4[0] : 10'h0);
      end
      checks++;
      if ({out_valid3, in_ready3} !== {q3.size() > 0, q3.size() < 2} ||
          (q3.size() > 0 && {out_src3, out_data3} !== q3[0])) begin
        errors++;
        $display("FAIL rand3 cycle %0d: got v=%b rdy=%b s=%0d d=%h, want depth=%0d head=%h",
                 c, out_valid3, in_ready3, out_src3, out_data3, q3.size(),
                 (q3.size() > 0) ? q3[0] : 10'h0);
      end
    end
    idle_inputs();
  endtask

  initial begin
    src_bus4 = 32'h44332211;
    src_bus3 = 24'h332211;
    reset_n  = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_back_to_back();
    test_streaming();
    test_flush();
    test_sel_err();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
